alu_seq_unit: RTL and testbench

Parametrised, handshaked successor to the 4-way add/sub/mult/div result mux. It accepts one operation at a time and computes it internally. Add, sub and mult complete in a single registered cycle. Div runs as an iterative restoring divider, one quotient bit per cycle. Results are held on a valid/ready output port. The block sits between the operand/opcode decode stage and the writeback stage of the datapath.

---
 rtl/alu_seq_pkg.sv | 18 +
 rtl/seq_divider.sv | 68 ++++++
 rtl/alu_seq_unit.sv | 110 +++++++++++
 tb/tb_alu_seq_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode and control-state encodings
// used by decode, the ALU itself and writeback.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring divider, MSB first, one quotient bit per clock.
// The first iteration happens on the start edge, so done rises after WIDTH edges.
module seq_divider #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  logic [WIDTH-1:0] src_rem, src_quo, src_div;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, quo_step;

  // One restoring step, fed either by fresh operands (start) or the running state.
  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_quo  = start ? dividend : quo_q;
    src_div  = start ? divisor : div_q;
    shifted  = {src_rem, src_quo[WIDTH-1]};
    diff     = shifted - {1'b0, src_div};
    rem_step = shifted[WIDTH-1:0];
    quo_step = {src_quo[WIDTH-2:0], 1'b0};
    if (shifted >= {1'b0, src_div}) begin
      rem_step = diff[WIDTH-1:0];
      quo_step = {src_quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      rem_q    <= rem_step;
      quo_q    <= quo_step;
      div_q    <= divisor;
      cnt_q    <= CNT_W'(WIDTH - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        rem_q <= rem_step;
        quo_q <= quo_step;
        cnt_q <= cnt_q - 1'b1;
      end else begin
        active_q <= 1'b0;
      end
    end
  end

  assign done      = active_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked add/sub/mult/div unit: single-cycle arithmetic ops, iterative divide,
// result held on a valid/ready port until writeback takes it.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             carry,
  output logic             div_by_zero,
  output logic             busy
);
  state_e           state_q;
  logic [WIDTH-1:0] result_q, remainder_q;
  logic             carry_q, dbz_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] prod;
  logic             div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign sum       = {1'b0, operand_a} + {1'b0, operand_b};
  assign prod      = operand_a * operand_b;
  assign div_start = in_valid && in_ready && (op_e'(op) == OP_DIV) && (operand_b != '0);

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (operand_a),
    .divisor  (operand_b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      remainder_q <= '0;
      carry_q     <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            remainder_q <= '0;
            carry_q     <= 1'b0;
            dbz_q       <= 1'b0;
            state_q     <= HOLD;
            unique case (op_e'(op))
              OP_ADD: begin
                result_q <= sum[WIDTH-1:0];
                carry_q  <= sum[WIDTH];
              end
              OP_SUB: begin
                result_q <= operand_a - operand_b;
                carry_q  <= operand_a < operand_b;
              end
              OP_MUL: result_q <= prod;
              OP_DIV: begin
                if (operand_b == '0) begin
                  result_q    <= '1;
                  remainder_q <= operand_a;
                  dbz_q       <= 1'b1;
                end else begin
                  result_q <= '0;
                  state_q  <= DIV;
                end
              end
            endcase
          end
        end
        DIV: begin
          if (div_done) begin
            result_q    <= div_quo;
            remainder_q <= div_rem;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == DIV);
  assign out_valid   = (state_q == HOLD);
  assign result      = result_q;
  assign remainder   = remainder_q;
  assign carry       = carry_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomised self-checking bench for alu_seq_unit against a plain-arithmetic model.
module tb_alu_seq_unit;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   op;
  logic [W-1:0] operand_a, operand_b, result, remainder;
  logic         carry, div_by_zero, busy;

  int total = 0;
  int bad   = 0;

  logic         exp_pending = 1'b0;
  logic [W-1:0] exp_r, exp_rm;
  logic         exp_c, exp_dz;

  always #5 clk = ~clk;

  alu_seq_unit #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .remainder  (remainder),
    .carry      (carry),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [W-1:0] rm,
                                output logic c, output logic dz);
    logic [W:0]     s;
    logic [2*W-1:0] p;
    r = '0; rm = '0; c = 1'b0; dz = 1'b0;
    case (o)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
      2'd1: begin r = a - b; c = (a < b); end
      2'd2: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; end
      default: begin
        if (b == 0) begin r = '1; rm = a; dz = 1'b1; end
        else begin r = a / b; rm = a % b; end
      end
    endcase
  endfunction

  // Checks the held result fields on every cycle the output port is valid.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (!exp_pending) check("unexpected_out_valid", 64'(out_valid), 64'd0);
      else begin
        check("result", result, exp_r);
        check("remainder", remainder, exp_rm);
        check("carry", 64'(carry), 64'(exp_c));
        check("div_by_zero", 64'(div_by_zero), 64'(exp_dz));
      end
    end
  end

  // Issue one op at a negedge, follow its timing, hold it for 'hold' backpressure cycles.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    int lat;
    model(o, a, b, exp_r, exp_rm, exp_c, exp_dz);
    lat = (o == 2'd3 && b != 0) ? W : 0;
    check("in_ready_before", 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; operand_a = a; operand_b = b; out_ready = 1'b0;
    exp_pending = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; op = 2'($urandom); operand_a = {$urandom, $urandom};
    operand_b = {$urandom, $urandom};
    for (int i = 0; i < lat; i++) begin
      if (out_valid || !busy || in_ready) begin
        check("div_busy_phase", {61'd0, out_valid, busy, in_ready}, 64'b010);
      end else total++;
      in_valid = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("valid_latency", {61'd0, out_valid, busy, in_ready}, 64'b100);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); operand_a = {$urandom, $urandom};
      @(negedge clk);
      check("hold_valid_noready", {62'd0, out_valid, in_ready}, 64'b10);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    exp_pending = 1'b0;
    out_ready = 1'b0;
    check("back_to_idle", {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] r, rm, a, b;
    logic         c, dz;
    logic [1:0]   o;

    // Pin the model itself with hand-computed values.
    model(2'd1, 64'd10, 64'd30, r, rm, c, dz);
    check("model_sub", r, 64'hFFFF_FFFF_FFFF_FFEC);
    check("model_sub_borrow", 64'(c), 64'd1);
    model(2'd3, 64'd70, 64'd3, r, rm, c, dz);
    check("model_div_q", r, 64'd23);
    check("model_div_r", rm, 64'd1);
    model(2'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, r, rm, c, dz);
    check("model_mul_wrap", r, 64'd0);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_state", {59'd0, in_ready, out_valid, busy, carry, div_by_zero}, 64'b10000);
    check("reset_result", result, 64'd0);
    check("reset_remainder", remainder, 64'd0);

    // Add with literal checks taken straight off the port.
    in_valid = 1'b1; op = 2'd0; operand_a = 64'd10; operand_b = 64'd30; out_ready = 1'b1;
    exp_r = 64'd40; exp_rm = '0; exp_c = 1'b0; exp_dz = 1'b0; exp_pending = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("add_lit_valid", 64'(out_valid), 64'd1);
    check("add_lit_result", result, 64'd40);
    @(negedge clk);
    exp_pending = 1'b0; out_ready = 1'b0;
    check("add_lit_idle", 64'(in_ready), 64'd1);

    run_op(2'd1, 64'd10, 64'd30, 0);
    run_op(2'd2, 64'd50, 64'd70, 1);
    run_op(2'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
    run_op(2'd3, 64'd70, 64'd3, 0);
    run_op(2'd3, 64'd3, 64'd70, 2);
    run_op(2'd3, 64'd70, 64'd0, 0);
    run_op(2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 10);

    // Reset in the middle of a division aborts it.
    in_valid = 1'b1; op = 2'd3; operand_a = 64'd1000; operand_b = 64'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("mid_div_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", {61'd0, out_valid, busy, in_ready}, 64'b001);
    repeat (3) @(negedge clk);
    check("abort_no_result", 64'(out_valid), 64'd0);
    run_op(2'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0);

    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom);
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = 64'($urandom_range(1, 20));
        2: b = {$urandom, $urandom};
        default: begin a = 64'($urandom_range(0, 1000)); b = a + 64'($urandom_range(1, 50)); end
      endcase
      run_op(o, a, b, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
